// File: rtl/spi_slave_if.sv
// Parallel-side and serial-side signals of the SPI responder.
interface spi_slave_if;
  localparam int unsigned DATA_W = 8;

  // Serial link pins
  logic              SPI_CLK_i;
  logic              SPI_SS_i;
  logic              SPI_MOSI_i;
  logic              SPI_MISO_o;

  // Local transmit/receive side
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              tx_underrun_o;
  logic              busy_o;

  modport slave (
    input  SPI_CLK_i,
    input  SPI_SS_i,
    input  SPI_MOSI_i,
    input  tx_data_i,
    input  tx_valid_i,
    output SPI_MISO_o,
    output tx_ready_o,
    output rx_data_o,
    output rx_valid_o,
    output tx_underrun_o,
    output busy_o
  );

  modport master (
    output SPI_CLK_i,
    output SPI_SS_i,
    output SPI_MOSI_i,
    output tx_data_i,
    output tx_valid_i,
    input  SPI_MISO_o,
    input  tx_ready_o,
    input  rx_data_o,
    input  rx_valid_o,
    input  tx_underrun_o,
    input  busy_o
  );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples the serial pins in the HCLK domain,
// deserialises MOSI into bytes and serialises a one-entry holding register
// onto MISO.
module spi_slave (
  input  logic        HCLK,
  input  logic        HRESETn,
  spi_slave_if.slave  bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam logic [DATA_W-1:0] FILL_BYTE = 8'hFF;
  localparam logic [CNT_W-1:0]  LAST_BIT  = 3'd7;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  // Synchroniser chains and edge-detect history
  logic [1:0] clk_sync;
  logic [1:0] ss_sync;
  logic [1:0] mosi_sync;
  logic       clk_hist;
  logic       ss_hist;

  logic sclk_s;
  logic ss_s;
  logic mosi_s;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_fall;
  logic ss_rise;

  // Datapath state
  logic [DATA_W-1:0] hold;
  logic              hold_empty;
  logic [DATA_W-1:0] shift_tx;
  logic [DATA_W-2:0] shift_rx;
  logic [CNT_W-1:0]  bit_cnt;
  logic              load_pending;

  // Registered outputs
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              underrun_q;
  logic              busy_q;
  logic              miso_q;

  // Per-cycle control decoded by the output process
  logic              do_load;
  logic              do_shift;
  logic              do_sample;
  logic              do_abort;
  logic              byte_done;
  logic              accept;
  logic [DATA_W-1:0] shift_tx_nx;
  logic              miso_nx;
  logic              busy_nx;
  logic              underrun_nx;

  // Two-flop synchronisers plus history flop for SCLK and SS
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      clk_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      clk_hist  <= 1'b0;
      ss_hist   <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.SPI_CLK_i};
      ss_sync   <= {ss_sync[0], bus.SPI_SS_i};
      mosi_sync <= {mosi_sync[0], bus.SPI_MOSI_i};
      clk_hist  <= clk_sync[1];
      ss_hist   <= ss_sync[1];
    end
  end

  assign sclk_s    = clk_sync[1];
  assign ss_s      = ss_sync[1];
  assign mosi_s    = mosi_sync[1];
  assign sclk_rise = sclk_s & ~clk_hist;
  assign sclk_fall = ~sclk_s & clk_hist;
  assign ss_fall   = ~ss_s & ss_hist;
  assign ss_rise   = ss_s & ~ss_hist;

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: selection opens and closes a transfer
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (ss_fall) state_nx = S_ACTIVE;
      S_ACTIVE: if (ss_rise) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Output/control decode; SS release takes priority over SCLK edges
  always_comb begin
    do_load   = 1'b0;
    do_shift  = 1'b0;
    do_sample = 1'b0;
    do_abort  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ss_fall) do_load = 1'b1;
      end
      S_ACTIVE: begin
        if (ss_rise) begin
          do_abort = 1'b1;
        end else if (sclk_rise) begin
          do_sample = 1'b1;
        end else if (sclk_fall) begin
          if (load_pending) do_load  = 1'b1;
          else              do_shift = 1'b1;
        end
      end
      default: ;
    endcase

    byte_done = do_sample && (bit_cnt == LAST_BIT);
    accept    = bus.tx_valid_i & hold_empty;

    // An empty holding register at a boundary sends the fill byte; a byte
    // accepted in the same cycle waits for the next boundary.
    shift_tx_nx = shift_tx;
    if (do_load) begin
      shift_tx_nx = hold_empty ? FILL_BYTE : hold;
    end else if (do_shift) begin
      shift_tx_nx = {shift_tx[DATA_W-2:0], 1'b0};
    end

    busy_nx     = (state_nx == S_ACTIVE);
    miso_nx     = busy_nx ? shift_tx_nx[DATA_W-1] : 1'b0;
    underrun_nx = do_load & hold_empty;
  end

  // Transmit holding register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold       <= '0;
      hold_empty <= 1'b1;
    end else begin
      if (accept) begin
        hold       <= bus.tx_data_i;
        hold_empty <= 1'b0;
      end else if (do_load && !hold_empty) begin
        hold_empty <= 1'b1;
      end
    end
  end

  // Shift registers, bit counter and byte-boundary bookkeeping
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      shift_tx     <= '0;
      shift_rx     <= '0;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      shift_tx <= shift_tx_nx;
      if (do_sample) begin
        shift_rx <= {shift_rx[DATA_W-3:0], mosi_s};
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (byte_done) begin
        rx_data_q    <= {shift_rx, mosi_s};
        load_pending <= 1'b1;
      end else if (do_load) begin
        load_pending <= 1'b0;
      end
      if (do_abort) begin
        bit_cnt      <= '0;
        load_pending <= 1'b0;
      end
    end
  end

  // Registered status and serial outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      rx_valid_q <= byte_done;
      underrun_q <= underrun_nx;
      busy_q     <= busy_nx;
      miso_q     <= miso_nx;
    end
  end

  assign bus.SPI_MISO_o    = miso_q;
  assign bus.tx_ready_o    = hold_empty;
  assign bus.rx_data_o     = rx_data_q;
  assign bus.rx_valid_o    = rx_valid_q;
  assign bus.tx_underrun_o = underrun_q;
  assign bus.busy_o        = busy_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: drives a mode-0 master on the pins and
// checks received bytes, MISO bytes and status pulses.
module tb_spi_slave;

  localparam int H = 6;  // SCLK half period in HCLK cycles

  logic HCLK;
  logic HRESETn;

  spi_slave_if intf();

  spi_slave dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (intf)
  );

  int checks = 0;
  int errors = 0;

  int rx_cnt  = 0;
  int und_cnt = 0;
  int und_snap = 0;
  logic [7:0] rx_log [0:63];

  logic [7:0] mosi_q   [0:7];
  logic [7:0] miso_cap [0:7];
  int         inject_idx = -1;
  logic [7:0] inject_data = 8'h00;
  logic       busy_mid = 1'b0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Count status pulses, sampled away from the active edge
  always @(negedge HCLK) begin
    if (intf.rx_valid_o) begin
      rx_log[rx_cnt[5:0]] = intf.rx_data_o;
      rx_cnt = rx_cnt + 1;
    end
    if (intf.tx_underrun_o) und_cnt = und_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Offer one byte to the holding register, bounded wait for ready
  task automatic push(input logic [7:0] d);
    int n;
    n = 0;
    while (!intf.tx_ready_o && n < 400) begin
      wait_cyc(1);
      n++;
    end
    check("push_ready_timeout", 32'(intf.tx_ready_o), 32'd1);
    intf.tx_data_i  = d;
    intf.tx_valid_i = 1'b1;
    wait_cyc(1);
    intf.tx_valid_i = 1'b0;
  endtask

  // Mode-0 master: drives nbits from mosi_q, captures MISO at each rise
  task automatic spi_xfer(input int nbits);
    intf.SPI_SS_i   = 1'b0;
    intf.SPI_MOSI_i = mosi_q[0][7];
    wait_cyc(H);
    busy_mid = intf.busy_o;
    for (int k = 0; k < nbits; k++) begin
      int bi;
      int bp;
      bi = k / 8;
      bp = 7 - (k % 8);
      intf.SPI_CLK_i = 1'b1;
      miso_cap[bi][bp] = intf.SPI_MISO_o;
      wait_cyc(H);
      if (k == nbits - 1) und_snap = und_cnt;
      intf.SPI_CLK_i = 1'b0;
      if (k + 1 < nbits) intf.SPI_MOSI_i = mosi_q[(k + 1) / 8][7 - ((k + 1) % 8)];
      if ((k % 8) == 7 && bi == inject_idx) begin
        // land tx_valid exactly on the reload cycle (third HCLK after the fall)
        wait_cyc(2);
        intf.tx_data_i  = inject_data;
        intf.tx_valid_i = 1'b1;
        wait_cyc(1);
        intf.tx_valid_i = 1'b0;
        wait_cyc(H - 3);
      end else begin
        wait_cyc(H);
      end
    end
    intf.SPI_SS_i = 1'b1;
    wait_cyc(H + 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int rx_base;
    int und_base;
    int n;

    intf.SPI_CLK_i  = 1'b0;
    intf.SPI_SS_i   = 1'b1;
    intf.SPI_MOSI_i = 1'b0;
    intf.tx_data_i  = 8'h00;
    intf.tx_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mosi_q[i]   = 8'h00;
      miso_cap[i] = 8'h00;
    end
    HRESETn = 1'b0;
    wait_cyc(4);

    // Reset values held while in reset
    check("rst_rx_data",  32'(intf.rx_data_o), 32'h00);
    check("rst_rx_valid", 32'(intf.rx_valid_o), 32'd0);
    check("rst_underrun", 32'(intf.tx_underrun_o), 32'd0);
    check("rst_busy",     32'(intf.busy_o), 32'd0);
    check("rst_miso",     32'(intf.SPI_MISO_o), 32'd0);
    check("rst_ready",    32'(intf.tx_ready_o), 32'd1);
    HRESETn = 1'b1;
    wait_cyc(10);
    check("rel_no_rx",  32'(rx_cnt), 32'd0);
    check("rel_no_und", 32'(und_cnt), 32'd0);

    // Single byte: A5 out, 3C in
    push(8'hA5);
    check("a5_ready_low", 32'(intf.tx_ready_o), 32'd0);
    rx_base  = rx_cnt;
    und_base = und_cnt;
    mosi_q[0] = 8'h3C;
    spi_xfer(8);
    check("a5_busy_mid",  32'(busy_mid), 32'd1);
    check("a5_miso",      32'(miso_cap[0]), 32'hA5);
    check("a5_rx_pulses", 32'(rx_cnt - rx_base), 32'd1);
    check("a5_rx_data",   32'(intf.rx_data_o), 32'h3C);
    check("a5_underrun",  32'(und_snap - und_base), 32'd0);
    check("a5_busy_end",  32'(intf.busy_o), 32'd0);
    check("a5_ready_end", 32'(intf.tx_ready_o), 32'd1);

    // Four bytes with only 11 and 22 supplied
    push(8'h11);
    rx_base  = rx_cnt;
    und_base = und_cnt;
    mosi_q[0] = 8'h81;
    mosi_q[1] = 8'h42;
    mosi_q[2] = 8'h24;
    mosi_q[3] = 8'h18;
    fork
      spi_xfer(32);
      begin
        n = 0;
        while (!intf.tx_ready_o && n < 300) begin
          wait_cyc(1);
          n++;
        end
        check("x4_reload_ready", 32'(intf.tx_ready_o), 32'd1);
        push(8'h22);
      end
    join
    check("x4_miso0", 32'(miso_cap[0]), 32'h11);
    check("x4_miso1", 32'(miso_cap[1]), 32'h22);
    check("x4_miso2", 32'(miso_cap[2]), 32'hFF);
    check("x4_miso3", 32'(miso_cap[3]), 32'hFF);
    check("x4_rx_pulses", 32'(rx_cnt - rx_base), 32'd4);
    check("x4_rx0", 32'(rx_log[rx_base[5:0]]), 32'h81);
    check("x4_rx1", 32'(rx_log[6'(rx_base + 1)]), 32'h42);
    check("x4_rx3", 32'(rx_log[6'(rx_base + 3)]), 32'h18);
    check("x4_underrun", 32'(und_snap - und_base), 32'd2);

    // Partial byte aborted by SS, then a full byte
    rx_base = rx_cnt;
    mosi_q[0] = 8'hF0;
    spi_xfer(5);
    check("part_no_rx",   32'(rx_cnt - rx_base), 32'd0);
    check("part_rx_hold", 32'(intf.rx_data_o), 32'h18);
    mosi_q[0] = 8'hC3;
    spi_xfer(8);
    check("c3_rx_pulses", 32'(rx_cnt - rx_base), 32'd1);
    check("c3_rx_data",   32'(intf.rx_data_o), 32'hC3);

    // Accept on the exact reload cycle with the holding register empty
    und_base = und_cnt;
    mosi_q[0] = 8'h00;
    mosi_q[1] = 8'h00;
    mosi_q[2] = 8'h00;
    inject_idx  = 0;
    inject_data = 8'h5A;
    spi_xfer(24);
    inject_idx = -1;
    check("inj_miso0", 32'(miso_cap[0]), 32'hFF);
    check("inj_miso1", 32'(miso_cap[1]), 32'hFF);
    check("inj_miso2", 32'(miso_cap[2]), 32'h5A);
    check("inj_underrun", 32'(und_snap - und_base), 32'd2);

    // Reset mid-byte, then a clean transfer
    push(8'hA5);
    intf.SPI_SS_i   = 1'b0;
    intf.SPI_MOSI_i = 1'b1;
    wait_cyc(H);
    for (int i = 0; i < 3; i++) begin
      intf.SPI_CLK_i = 1'b1;
      wait_cyc(H);
      intf.SPI_CLK_i = 1'b0;
      wait_cyc(H);
    end
    HRESETn = 1'b0;
    wait_cyc(2);
    check("mrst_busy",    32'(intf.busy_o), 32'd0);
    check("mrst_miso",    32'(intf.SPI_MISO_o), 32'd0);
    check("mrst_ready",   32'(intf.tx_ready_o), 32'd1);
    check("mrst_rx_data", 32'(intf.rx_data_o), 32'h00);
    intf.SPI_SS_i = 1'b1;
    intf.SPI_CLK_i = 1'b0;
    wait_cyc(3);
    HRESETn = 1'b1;
    wait_cyc(10);
    push(8'h96);
    rx_base  = rx_cnt;
    und_base = und_cnt;
    mosi_q[0] = 8'h69;
    spi_xfer(8);
    check("post_miso",      32'(miso_cap[0]), 32'h96);
    check("post_rx_pulses", 32'(rx_cnt - rx_base), 32'd1);
    check("post_rx_data",   32'(intf.rx_data_o), 32'h69);
    check("post_underrun",  32'(und_snap - und_base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
